// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller and the memory system.
interface mem_access_ctrl_if;
   logic        dbus_req_o;
   logic        dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [3:0]  dbus_be_o;
   logic [31:0] dbus_wdata_o;
   logic        dbus_ack_i;
   logic [31:0] dbus_rdata_i;

   modport master (
      output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
      input  dbus_ack_i, dbus_rdata_i
   );

   modport slave (
      input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
      output dbus_ack_i, dbus_rdata_i
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: drives a req/ack data bus, stalls the pipeline
// until the access finishes, and formats load data for writeback.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_ctrl_valid_i,
   input  logic [3:0]        mem_ctrl_op_i,
   input  logic [31:0]       mem_ctrl_addr_i,
   input  logic [31:0]       mem_ctrl_sdata_i,
   input  logic [31:0]       mem_ctrl_wdata_i,
   input  logic [4:0]        mem_ctrl_waddr_i,
   input  logic              mem_ctrl_we_i,
   mem_access_ctrl_if.master dbus,
   output logic              mem_ctrl_stall_o,
   output logic [31:0]       mem_ctrl_wdata_o,
   output logic [4:0]        mem_ctrl_waddr_o,
   output logic              mem_ctrl_we_o,
   output logic              mem_ctrl_misalign_o,
   output logic              mem_ctrl_buserr_o
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state_q, state_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;
   logic [3:0]        op_q, op_nxt;
   logic [1:0]        off_q, off_nxt;
   logic [4:0]        waddr_q, waddr_nxt;
   logic              we_q, we_nxt;
   logic              err_q, err_nxt;
   logic [31:0]       rdata_q, rdata_nxt;
   logic              req_nxt, bwe_nxt;
   logic [31:0]       baddr_nxt, bwdata_nxt;
   logic [3:0]        be_nxt;

   logic              memop_c, misal_c, is_half_c, is_word_c, is_store_c, is_load_q_c;
   logic [3:0]        be_fmt_c;
   logic [31:0]       wdata_fmt_c, ld_data_c;
   logic [7:0]        ld_byte_c;
   logic [15:0]       ld_half_c;

   // Decode and alignment of the op currently in the MEM stage
   always_comb begin
      memop_c    = mem_ctrl_valid_i && (mem_ctrl_op_i >= OP_LB) && (mem_ctrl_op_i <= OP_SW);
      is_half_c  = (mem_ctrl_op_i == OP_LH) || (mem_ctrl_op_i == OP_LHU) || (mem_ctrl_op_i == OP_SH);
      is_word_c  = (mem_ctrl_op_i == OP_LW) || (mem_ctrl_op_i == OP_SW);
      is_store_c = (mem_ctrl_op_i >= OP_SB) && (mem_ctrl_op_i <= OP_SW);
      misal_c    = (is_half_c && mem_ctrl_addr_i[0]) || (is_word_c && (mem_ctrl_addr_i[1:0] != 2'b00));
   end

   // Store lane formatting; loads read the whole word
   always_comb begin
      be_fmt_c    = 4'b1111;
      wdata_fmt_c = '0;
      case (mem_ctrl_op_i)
         OP_SB: begin
            be_fmt_c    = 4'b0001 << mem_ctrl_addr_i[1:0];
            wdata_fmt_c = {4{mem_ctrl_sdata_i[7:0]}};
         end
         OP_SH: begin
            be_fmt_c    = mem_ctrl_addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_fmt_c = {2{mem_ctrl_sdata_i[15:0]}};
         end
         OP_SW:   wdata_fmt_c = mem_ctrl_sdata_i;
         default: ;
      endcase
   end

   // Load extraction from the captured read word
   always_comb begin
      is_load_q_c = (op_q >= OP_LB) && (op_q <= OP_LW);
      ld_byte_c   = rdata_q[{off_q, 3'b000} +: 8];
      ld_half_c   = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (op_q)
         OP_LB:   ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
         OP_LBU:  ld_data_c = {24'd0, ld_byte_c};
         OP_LH:   ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
         OP_LHU:  ld_data_c = {16'd0, ld_half_c};
         default: ld_data_c = rdata_q;
      endcase
   end

   // Next-state, latch updates and MEM/WB outputs
   always_comb begin
      state_nxt           = state_q;
      cnt_nxt             = '0;
      op_nxt              = op_q;
      off_nxt             = off_q;
      waddr_nxt           = waddr_q;
      we_nxt              = we_q;
      err_nxt             = err_q;
      rdata_nxt           = rdata_q;
      req_nxt             = dbus.dbus_req_o;
      bwe_nxt             = dbus.dbus_we_o;
      baddr_nxt           = dbus.dbus_addr_o;
      be_nxt              = dbus.dbus_be_o;
      bwdata_nxt          = dbus.dbus_wdata_o;
      mem_ctrl_stall_o    = 1'b0;
      mem_ctrl_wdata_o    = mem_ctrl_wdata_i;
      mem_ctrl_waddr_o    = mem_ctrl_waddr_i;
      mem_ctrl_we_o       = mem_ctrl_we_i && mem_ctrl_valid_i;
      mem_ctrl_misalign_o = 1'b0;
      mem_ctrl_buserr_o   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (memop_c && misal_c) begin
               mem_ctrl_misalign_o = 1'b1;
               mem_ctrl_we_o       = 1'b0;
            end else if (memop_c) begin
               mem_ctrl_stall_o = 1'b1;
               state_nxt        = S_BUSY;
               op_nxt           = mem_ctrl_op_i;
               off_nxt          = mem_ctrl_addr_i[1:0];
               waddr_nxt        = mem_ctrl_waddr_i;
               we_nxt           = mem_ctrl_we_i;
               err_nxt          = 1'b0;
               req_nxt          = 1'b1;
               bwe_nxt          = is_store_c;
               baddr_nxt        = {mem_ctrl_addr_i[31:2], 2'b00};
               be_nxt           = be_fmt_c;
               bwdata_nxt       = wdata_fmt_c;
            end
         end
         S_BUSY: begin
            mem_ctrl_stall_o = 1'b1;
            cnt_nxt          = cnt_q + CNT_W'(1);
            if (dbus.dbus_ack_i) begin
               rdata_nxt = dbus.dbus_rdata_i;
               req_nxt   = 1'b0;
               state_nxt = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               req_nxt   = 1'b0;
               err_nxt   = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            mem_ctrl_wdata_o  = ld_data_c;
            mem_ctrl_waddr_o  = waddr_q;
            mem_ctrl_we_o     = is_load_q_c && !err_q && we_q;
            mem_ctrl_buserr_o = err_q;
            state_nxt         = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      if (rst) begin
         mem_ctrl_stall_o    = 1'b0;
         mem_ctrl_wdata_o    = '0;
         mem_ctrl_waddr_o    = '0;
         mem_ctrl_we_o       = 1'b0;
         mem_ctrl_misalign_o = 1'b0;
         mem_ctrl_buserr_o   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_nxt;
   end

   // Latched access context and registered bus outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q              <= '0;
         op_q               <= '0;
         off_q              <= '0;
         waddr_q            <= '0;
         we_q               <= 1'b0;
         err_q              <= 1'b0;
         rdata_q            <= '0;
         dbus.dbus_req_o    <= 1'b0;
         dbus.dbus_we_o     <= 1'b0;
         dbus.dbus_addr_o   <= '0;
         dbus.dbus_be_o     <= '0;
         dbus.dbus_wdata_o  <= '0;
      end else begin
         cnt_q              <= cnt_nxt;
         op_q               <= op_nxt;
         off_q              <= off_nxt;
         waddr_q            <= waddr_nxt;
         we_q               <= we_nxt;
         err_q              <= err_nxt;
         rdata_q            <= rdata_nxt;
         dbus.dbus_req_o    <= req_nxt;
         dbus.dbus_we_o     <= bwe_nxt;
         dbus.dbus_addr_o   <= baddr_nxt;
         dbus.dbus_be_o     <= be_nxt;
         dbus.dbus_wdata_o  <= bwdata_nxt;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases plus randomized accesses against a
// transaction-level model of bus formatting, load extension and stall timing.
module tb_mem_access_ctrl;
   localparam int unsigned TIMEOUT = 16;

   logic        clk;
   logic        rst;
   logic        valid;
   logic [3:0]  op;
   logic [31:0] addr, sdata, wdata;
   logic [4:0]  waddr;
   logic        we;
   logic        stall, we_o, misalign, buserr;
   logic [31:0] wdata_o;
   logic [4:0]  waddr_o;

   int total = 0;
   int bad   = 0;

   mem_access_ctrl_if dbus ();

   mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .mem_ctrl_valid_i    (valid),
      .mem_ctrl_op_i       (op),
      .mem_ctrl_addr_i     (addr),
      .mem_ctrl_sdata_i    (sdata),
      .mem_ctrl_wdata_i    (wdata),
      .mem_ctrl_waddr_i    (waddr),
      .mem_ctrl_we_i       (we),
      .dbus                (dbus),
      .mem_ctrl_stall_o    (stall),
      .mem_ctrl_wdata_o    (wdata_o),
      .mem_ctrl_waddr_o    (waddr_o),
      .mem_ctrl_we_o       (we_o),
      .mem_ctrl_misalign_o (misalign),
      .mem_ctrl_buserr_o   (buserr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: read-side value delivered to writeback
   function automatic logic [31:0] ld_model(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] rd);
      logic [31:0] v;
      v = rd >> (8 * a[1:0]);
      case (o)
         4'd1:    begin v = v % 256;   if (v >= 128)   v = v - 256;   end
         4'd2:    v = v % 256;
         4'd3:    begin v = v % 65536; if (v >= 32768) v = v - 65536; end
         4'd4:    v = v % 65536;
         default: v = rd;
      endcase
      return v;
   endfunction

   // Reference: byte enables presented on the bus
   function automatic logic [3:0] be_model(input logic [3:0] o, input logic [31:0] a);
      case (o)
         4'd6:    return 4'(1 << a[1:0]);
         4'd7:    return 4'(3 << a[1:0]);
         default: return 4'hF;
      endcase
   endfunction

   // Reference: store data presented on the bus
   function automatic logic [31:0] sd_model(input logic [3:0] o, input logic [31:0] s);
      case (o)
         4'd6:    return (s % 256) * 32'h0101_0101;
         4'd7:    return (s % 65536) * 32'h0001_0001;
         default: return s;
      endcase
   endfunction

   // One instruction in the MEM stage; k = ack delay after req rises, k<0 = never ack.
   // Entered and left just after a rising edge with the controller idle.
   task automatic do_acc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] s,
                         input logic [31:0] wd, input logic [4:0] wa, input logic w,
                         input logic [31:0] rd, input int k);
      logic memop, mis, is_load, is_store, tout;
      int   stalls;
      memop    = (o >= 4'd1) && (o <= 4'd8);
      is_load  = (o >= 4'd1) && (o <= 4'd5);
      is_store = (o >= 4'd6) && (o <= 4'd8);
      mis      = ((o == 4'd3 || o == 4'd4 || o == 4'd7) && (a % 2 != 0)) ||
                 ((o == 4'd5 || o == 4'd8) && (a % 4 != 0));
      tout     = !(k >= 0 && k < int'(TIMEOUT));
      valid = 1'b1; op = o; addr = a; sdata = s; wdata = wd; waddr = wa; we = w;
      dbus.dbus_ack_i = 1'b0; dbus.dbus_rdata_i = $urandom;
      @(negedge clk);
      if (!memop) begin
         chk("pass_wdata", wdata_o, wd);
         chk("pass_waddr", 32'(waddr_o), 32'(wa));
         chk("pass_we", 32'(we_o), 32'(w));
         chk("pass_stall", 32'(stall), 0);
         tick();
         return;
      end
      if (mis) begin
         chk("mis_pulse", 32'(misalign), 1);
         chk("mis_we", 32'(we_o), 0);
         chk("mis_stall", 32'(stall), 0);
         tick();
         valid = 1'b0;
         @(negedge clk);
         chk("mis_noreq", 32'(dbus.dbus_req_o), 0);
         chk("mis_clear", 32'(misalign), 0);
         tick();
         return;
      end
      chk("acc_stall0", 32'(stall), 1);
      chk("acc_req0", 32'(dbus.dbus_req_o), 0);
      chk("acc_mis0", 32'(misalign), 0);
      stalls = 1;
      for (int j = 0; j < int'(TIMEOUT); j++) begin
         tick();
         dbus.dbus_ack_i   = (j == k);
         dbus.dbus_rdata_i = (j == k) ? rd : $urandom;
         @(negedge clk);
         chk("busy_req", 32'(dbus.dbus_req_o), 1);
         chk("busy_addr", dbus.dbus_addr_o, a & 32'hFFFF_FFFC);
         chk("busy_be", 32'(dbus.dbus_be_o), 32'(be_model(o, a)));
         chk("busy_we", 32'(dbus.dbus_we_o), 32'(is_store));
         if (is_store) chk("busy_wdata", dbus.dbus_wdata_o, sd_model(o, s));
         if (stall) stalls++;
         if (j == k) break;
      end
      tick();
      dbus.dbus_ack_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("done_stall", 32'(stall), 0);
      chk("done_req", 32'(dbus.dbus_req_o), 0);
      chk("done_buserr", 32'(buserr), 32'(tout));
      chk("stall_cycles", 32'(stalls), tout ? TIMEOUT + 1 : 32'(k + 2));
      chk("done_we", 32'(we_o), 32'(is_load && !tout && w));
      if (is_load && !tout) begin
         chk("done_wdata", wdata_o, ld_model(o, a, rd));
         chk("done_waddr", 32'(waddr_o), 32'(wa));
      end
      tick();
      dbus.dbus_ack_i = 1'b0;
   endtask

   initial begin
      rst = 1'b1; valid = 1'b1; op = 4'd0; addr = '0; sdata = '0;
      wdata = 32'hDEAD_BEEF; waddr = 5'd9; we = 1'b1;
      dbus.dbus_ack_i = 1'b0; dbus.dbus_rdata_i = '0;
      tick(); tick();
      @(negedge clk);
      chk("rst_wdata", wdata_o, 0);
      chk("rst_we", 32'(we_o), 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_req", 32'(dbus.dbus_req_o), 0);
      chk("rst_be", 32'(dbus.dbus_be_o), 0);
      tick();
      rst = 1'b0;

      // directed cases
      do_acc(4'd0, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 32'h0, 0);
      do_acc(4'd1, 32'h103, 32'h0, 32'h0, 5'd7, 1'b1, 32'h80FF_0000, 2);
      do_acc(4'd2, 32'h103, 32'h0, 32'h0, 5'd7, 1'b1, 32'h80FF_0000, 2);
      do_acc(4'd7, 32'h22, 32'hAAAA_BEEF, 32'h0, 5'd1, 1'b0, 32'h0, 0);
      do_acc(4'd5, 32'h41, 32'h0, 32'h0, 5'd2, 1'b1, 32'h0, 0);
      do_acc(4'd5, 32'h80, 32'h0, 32'h0, 5'd2, 1'b1, 32'h0, -1);
      do_acc(4'd3, 32'h12, 32'h0, 32'h0, 5'd4, 1'b1, 32'h8001_7FFF, 15);
      do_acc(4'd6, 32'h3, 32'h1234_56A5, 32'h0, 5'd0, 1'b0, 32'h0, 1);

      // reset in the middle of an access, then a late ack
      valid = 1'b1; op = 4'd5; addr = 32'h200; waddr = 5'd3; we = 1'b1;
      tick();
      @(negedge clk);
      chk("mid_req_up", 32'(dbus.dbus_req_o), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_stall", 32'(stall), 0);
      chk("mid_rst_we", 32'(we_o), 0);
      tick();
      rst = 1'b0; valid = 1'b0; dbus.dbus_ack_i = 1'b1;
      @(negedge clk);
      chk("mid_req_down", 32'(dbus.dbus_req_o), 0);
      chk("mid_stall", 32'(stall), 0);
      chk("mid_we", 32'(we_o), 0);
      tick();
      dbus.dbus_ack_i = 1'b0;
      @(negedge clk);
      chk("late_ack_req", 32'(dbus.dbus_req_o), 0);
      tick();
      do_acc(4'd5, 32'h204, 32'h0, 32'h0, 5'd3, 1'b1, 32'hCAFE_F00D, 1);

      // randomized, back-to-back
      for (int i = 0; i < 60; i++) begin
         logic [3:0]  ro;
         logic [31:0] ra;
         int          rk;
         ro = 4'($urandom_range(0, 15));
         ra = $urandom;
         if ($urandom_range(0, 1) == 1) ra = ra & 32'hFFFF_FFFC;
         rk = int'($urandom_range(0, 9));
         rk = (rk == 9) ? -1 : rk % 5;
         do_acc(ro, ra, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom, rk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
